// File: rtl/arith_pkg.sv
// Shared opcodes, sign selects and FSM states for the
// sequential multiply/divide unit.
package arith_pkg;

  localparam logic OP_MUL       = 1'b0;
  localparam logic OP_DIV       = 1'b1;
  localparam logic SEL_UNSIGNED = 1'b0;
  localparam logic SEL_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/arith_cond_negate.sv
// Two's complement conditional negate: out = neg ? -in : in.
// Used for operand magnitudes and result sign correction.
module arith_cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  output logic [WIDTH-1:0] out_val
);

  always_comb begin
    out_val = neg ? (~in_val + WIDTH'(1)) : in_val;
  end

endmodule

// File: rtl/arith_seq_muldiv.sv
// Radix-2 sequential signed/unsigned multiply-divide unit.
// Shared adder serves shift-add MUL and restoring DIV.
module arith_seq_muldiv
  import arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             OpCode,
  input  logic             S_or_U,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] ArithAnswerOne,
  output logic [WIDTH-1:0] ArithAnswerTwo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic               sgn_q, sgn_d;
  logic               prep_q, prep_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   ans1_q, ans1_d;
  logic [WIDTH-1:0]   ans2_q, ans2_d;
  logic               dbz_q, dbz_d;

  logic               signed_op;
  logic               neg_a, neg_b, neg_p;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [W2-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_x, add_y;
  logic               add_ci;
  logic [WIDTH+1:0]   sum_w;
  logic               qbit;
  logic [WIDTH-1:0]   rem_new;

  assign signed_op = (sgn_q == SEL_SIGNED);
  assign neg_a     = signed_op & a_q[WIDTH-1];
  assign neg_b     = signed_op & b_q[WIDTH-1];
  assign neg_p     = neg_a ^ neg_b;

  arith_cond_negate #(.WIDTH(WIDTH)) u_mag_a (
    .in_val (a_q),
    .neg    (neg_a),
    .out_val(mag_a)
  );

  arith_cond_negate #(.WIDTH(WIDTH)) u_mag_b (
    .in_val (b_q),
    .neg    (neg_b),
    .out_val(mag_b)
  );

  arith_cond_negate #(.WIDTH(W2)) u_fix_prod (
    .in_val (acc_q),
    .neg    (neg_p),
    .out_val(prod_fix)
  );

  arith_cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .in_val (sr_q),
    .neg    (neg_p),
    .out_val(quo_fix)
  );

  arith_cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .in_val (acc_q[W2-1:WIDTH]),
    .neg    (neg_a),
    .out_val(rem_fix)
  );

  // DIV subtracts via x + ~y + 1; the top carry means no borrow
  always_comb begin
    addend = sr_q[0] ? mag_a : '0;
    if (op_q == OP_DIV) begin
      add_x  = {acc_q[W2-1:WIDTH], sr_q[WIDTH-1]};
      add_y  = ~{1'b0, mag_b};
      add_ci = 1'b1;
    end else begin
      add_x  = {1'b0, acc_q[W2-1:WIDTH]};
      add_y  = {1'b0, addend};
      add_ci = 1'b0;
    end
    sum_w   = {1'b0, add_x} + {1'b0, add_y}
            + {{(WIDTH+1){1'b0}}, add_ci};
    qbit    = sum_w[WIDTH+1];
    rem_new = qbit ? sum_w[WIDTH-1:0] : add_x[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    prep_d  = prep_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    ans1_d  = ans1_q;
    ans2_d  = ans2_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          a_d     = A;
          b_d     = B;
          op_d    = OpCode;
          sgn_d   = S_or_U;
          prep_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      CALC: begin
        // first CALC cycle loads the registered magnitudes
        if (prep_q) begin
          prep_d = 1'b0;
          acc_d  = '0;
          sr_d   = (op_q == OP_DIV) ? mag_a : mag_b;
        end else begin
          if (op_q == OP_DIV) begin
            acc_d = {rem_new, acc_q[WIDTH-1:0]};
            sr_d  = {sr_q[WIDTH-2:0], qbit};
          end else begin
            acc_d = {sum_w[WIDTH:0], acc_q[WIDTH-1:1]};
            sr_d  = sr_q >> 1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = DONE;
        if (op_q == OP_MUL) begin
          ans1_d = prod_fix[WIDTH-1:0];
          ans2_d = prod_fix[W2-1:WIDTH];
          dbz_d  = 1'b0;
        end else if (b_q == '0) begin
          ans1_d = '1;
          ans2_d = a_q;
          dbz_d  = 1'b1;
        end else begin
          ans1_d = quo_fix;
          ans2_d = rem_fix;
          dbz_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      sgn_q   <= SEL_UNSIGNED;
      prep_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sr_q    <= '0;
      ans1_q  <= '0;
      ans2_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      prep_q  <= prep_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      ans1_q  <= ans1_d;
      ans2_q  <= ans2_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy           = (state_q == CALC) || (state_q == FIX);
  assign done           = (state_q == DONE);
  assign div_by_zero    = dbz_q;
  assign ArithAnswerOne = ans1_q;
  assign ArithAnswerTwo = ans2_q;

endmodule

// File: tb/tb_arith_seq_muldiv.sv
// Scoreboard bench for arith_seq_muldiv (WIDTH=32):
// stimulus pushes model results, monitor pops on done.
module tb_arith_seq_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         OpCode = 1'b0;
  logic         S_or_U = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] ArithAnswerOne, ArithAnswerTwo;

  typedef struct {
    logic [W-1:0] one;
    logic [W-1:0] two;
    logic         dbz;
    int           t;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   in_rst = 1'b1;

  arith_seq_muldiv #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .OpCode        (OpCode),
    .S_or_U        (S_or_U),
    .A             (A),
    .B             (B),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .ArithAnswerOne(ArithAnswerOne),
    .ArithAnswerTwo(ArithAnswerTwo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the operation definitions
  function automatic exp_t model(input logic op, input logic sgn,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    logic [63:0] pb;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    e.t = 0;
    if (!op) begin
      p     = sa * sb;
      pb    = p;
      e.one = pb[31:0];
      e.two = pb[63:32];
      e.dbz = 1'b0;
    end else if (b == 0) begin
      e.one = 32'hFFFF_FFFF;
      e.two = a;
      e.dbz = 1'b1;
    end else begin
      q     = sa / sb;
      r     = sa % sb;
      e.one = q[31:0];
      e.two = r[31:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic op, input logic sgn,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    e   = model(op, sgn, a, b);
    e.t = cyc + 1;
    sbq.push_back(e);
    OpCode = op;
    S_or_U = sgn;
    A      = a;
    B      = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd0;
      3: v = 32'd1;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: result compare, latency, done width and hold between dones
  logic [W-1:0] last1 = '0, last2 = '0;
  logic         lastdbz = 1'b0;
  logic         done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (in_rst) begin
      last1     = '0;
      last2     = '0;
      lastdbz   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (done) begin
        chk("done_width", 64'(done_prev), 64'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else if (!done_prev) begin
          e = sbq.pop_front();
          chk("answer_one", 64'(ArithAnswerOne), 64'(e.one));
          chk("answer_two", 64'(ArithAnswerTwo), 64'(e.two));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("latency", 64'(cyc - e.t), 64'(W + 2));
        end
        last1   = ArithAnswerOne;
        last2   = ArithAnswerTwo;
        lastdbz = div_by_zero;
      end else begin
        chk("hold", {ArithAnswerOne, ArithAnswerTwo},
            {last1, last2});
        chk("hold_dbz", 64'(div_by_zero), 64'(lastdbz));
      end
      done_prev = done;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_ans", {ArithAnswerOne, ArithAnswerTwo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;

    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3);
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    issue(1'b1, 1'b0, 32'h1234, 32'd0);
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    issue(1'b1, 1'b1, 32'h8000_0000, 32'd0);
    issue(1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);

    // start during busy with new operands is ignored
    issue(1'b0, 1'b0, 32'd1000, 32'd3000);
    repeat (5) @(negedge clk);
    OpCode = 1'b1;
    A      = 32'd55;
    B      = 32'd5;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // start in the DONE cycle is ignored
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 64'(done), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_in_done_busy", 64'(busy), 64'd0);
    issue(1'b1, 1'b0, 32'd55, 32'd5);

    // reset ten cycles into a divide aborts it
    issue(1'b1, 1'b0, 32'd999, 32'd10);
    repeat (9) @(negedge clk);
    in_rst = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sbq.pop_back());
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ans", {ArithAnswerOne, ArithAnswerTwo}, 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    in_rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 500; i++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_opnd(), rand_opnd());
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
